// File: rtl/lzrw1_pkg.sv
// Shared byte type and widths for the LZRW1 output packer and its benches.
package lzrw1_pkg;

  localparam int BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  // FIFO entry holds {last, keep, data} for one packed word.
  function automatic int entry_w(input int bytes);
    return (BYTE_W + 1) * bytes + 1;
  endfunction

endpackage

// File: rtl/lzrw1_byte_packer_if.sv
// Byte-in / word-out stream bundle for lzrw1_byte_packer.
interface lzrw1_byte_packer_if #(
  parameter int BYTES = 4
);
  import lzrw1_pkg::*;

  logic               in_valid;
  byte_t              in_byte;
  logic               in_last;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic [8*BYTES-1:0] out_data;
  logic [BYTES-1:0]   out_keep;
  logic               out_last;

  modport slave (
    input  in_valid, in_byte, in_last, out_ready,
    output in_ready, out_valid, out_data, out_keep, out_last
  );

  modport master (
    output in_valid, in_byte, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_keep, out_last
  );

endinterface

// File: rtl/lzrw1_sync_fifo.sv
// Single-clock FIFO with occupancy count; storage is not reset.
module lzrw1_sync_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lzrw1_byte_packer.sv
// Packs decompressed bytes into BYTES-wide words with keep/last via a FIFO.
// Optional LZRW1_PACKER_BYTE_COUNT_EN adds frame_bytes / frame_done.
module lzrw1_byte_packer
  import lzrw1_pkg::*;
#(
  parameter int BYTES = 4,
  parameter int DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  lzrw1_byte_packer_if.slave  bus
`ifdef LZRW1_PACKER_BYTE_COUNT_EN
  ,
  output logic [31:0]         frame_bytes,
  output logic [0:0]          frame_done
`endif
);
  localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int EW = entry_w(BYTES);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [IW-1:0]      index;
  byte_t              lane [BYTES];
  logic               accept;
  logic               close;
  logic [8*BYTES-1:0] word_data;
  logic [BYTES-1:0]   word_keep;
  logic [EW-1:0]      fifo_din;
  logic [EW-1:0]      fifo_dout;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;

  assign bus.in_ready = !reset && (fifo_count < CW'(DEPTH));
  assign accept       = bus.in_valid && bus.in_ready;
  assign close        = accept &&
                        (bus.in_last || index == IW'(BYTES - 1));

  // Completed word: held lanes below index, current byte at index.
  always_comb begin
    word_data = '0;
    word_keep = '0;
    for (int i = 0; i < BYTES; i++) begin
      if (i < int'(index)) begin
        word_data[i*8 +: 8] = lane[i];
        word_keep[i]        = 1'b1;
      end else if (i == int'(index)) begin
        word_data[i*8 +: 8] = bus.in_byte;
        word_keep[i]        = 1'b1;
      end
    end
  end

  assign fifo_din = {bus.in_last, word_keep, word_data};

  always_ff @(posedge clock) begin
    if (reset) begin
      index <= '0;
      for (int i = 0; i < BYTES; i++) lane[i] <= '0;
    end else if (accept) begin
      if (close) begin
        index <= '0;
        for (int i = 0; i < BYTES; i++) lane[i] <= '0;
      end else begin
        lane[index] <= bus.in_byte;
        index       <= index + IW'(1);
      end
    end
  end

  lzrw1_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (close && !fifo_full),
    .pop   (bus.out_ready),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Zero the bus when empty so stale storage never shows.
  assign bus.out_valid = !fifo_empty;
  assign {bus.out_last, bus.out_keep, bus.out_data} =
    fifo_empty ? '0 : fifo_dout;

`ifdef LZRW1_PACKER_BYTE_COUNT_EN
  logic [31:0] fb_base;

  assign fb_base = frame_done[0] ? 32'd0 : frame_bytes;

  always_ff @(posedge clock) begin
    if (reset) begin
      frame_bytes <= '0;
      frame_done  <= '0;
    end else begin
      frame_done <= accept && bus.in_last;
      if (accept) begin
        frame_bytes <= (&fb_base) ? fb_base : fb_base + 32'd1;
      end else if (frame_done[0]) begin
        frame_bytes <= '0;
      end
    end
  end
`endif

endmodule
